// File: rtl/jt51_slot_seq.sv
// Slot sequencer and modulation-routing controller for the JT51 FM operator pipeline.
// Optional macro JT51_SEQ_CARRIER_EN adds the registered 'carrier' output.
module jt51_slot_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       wr,
  input  logic [2:0] wr_ch,
  input  logic [2:0] wr_con,
  input  logic [2:0] wr_fb,
  output logic [4:0] slot,
  output logic       zero,
  output logic       m1_enters,
  output logic       m2_enters,
  output logic       c1_enters,
  output logic       c2_enters,
  output logic       use_prevprev1,
  output logic       use_prev1,
  output logic       use_prev2,
  output logic       use_internal_x,
  output logic       use_internal_y,
  output logic [2:0] fb_II,
  output logic [2:0] con_I
`ifdef JT51_SEQ_CARRIER_EN
  ,
  output logic       carrier
`endif
);

  typedef enum logic [1:0] {OP_M1, OP_M2, OP_C1, OP_C2} op_e;

  typedef struct packed {
    logic [4:0] slot;
    logic       zero;
    logic       m1;
    logic       m2;
    logic       c1;
    logic       c2;
    logic       prevprev1;
    logic       prev1;
    logic       prev2;
    logic       internal_x;
    logic       internal_y;
    logic [2:0] fb;
    logic [2:0] con;
`ifdef JT51_SEQ_CARRIER_EN
    logic       carrier;
`endif
  } out_t;

  logic [4:0]      cnt_q, cnt_d;
  logic [7:0][2:0] con_q, con_d;
  logic [7:0][2:0] fb_q, fb_d;
  out_t            out_q, out_d;

  op_e        op;
  logic [2:0] con_sel;
  logic [7:0] a;

  // NOTE: every variable gets a default before any branch, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    con_d   = con_q;
    fb_d    = fb_q;
    out_d   = out_q;
    op      = OP_M1;
    con_sel = 3'd0;
    a       = 8'd0;

    if (cen) begin
      cnt_d   = cnt_q + 5'd1;
      op      = op_e'(cnt_d[4:3]);
      con_sel = con_q[cnt_d[2:0]];
      a       = 8'd1 << con_sel;

      out_d.slot = cnt_d;
      out_d.zero = (cnt_d == 5'd0);
      out_d.m1   = (op == OP_M1);
      out_d.m2   = (op == OP_M2);
      out_d.c1   = (op == OP_C1);
      out_d.c2   = (op == OP_C2);
      out_d.con  = con_sel;

      out_d.prevprev1  = out_d.m1 | (out_d.m2 & a[5]);
      out_d.prev2      = (out_d.m2 & (a[0] | a[1] | a[2])) | (out_d.c2 & a[3]);
      out_d.internal_x = out_d.c2 & a[2];
      out_d.internal_y = out_d.c2 & (a[0] | a[1] | a[3] | a[4]);
      out_d.prev1      = out_d.m1 | (out_d.m2 & a[1])
                       | (out_d.c1 & (a[0] | a[3] | a[5] | a[6]))
                       | (out_d.c2 & (a[2] | a[5]));
`ifdef JT51_SEQ_CARRIER_EN
      out_d.carrier = out_d.c2 | (out_d.m2 & (con_sel >= 3'd4))
                    | (out_d.c1 & (con_sel >= 3'd5)) | (out_d.m1 & (con_sel == 3'd7));
`endif
      // Feedback belongs to the slot being left, and only M1 operators self-modulate.
      out_d.fb = (cnt_q[4:3] == 2'd0) ? fb_q[cnt_q[2:0]] : 3'd0;
    end

    // Writes ignore cen; the decode above already used the pre-write contents.
    if (wr) begin
      con_d[wr_ch] = wr_con;
      fb_d[wr_ch]  = wr_fb;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 5'd31;
      out_q <= '0;
      // NOTE: the register file is small and its contents are architecturally
      // defined after reset, so it is cleared like ordinary flops.
      con_q <= '0;
      fb_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
      con_q <= con_d;
      fb_q  <= fb_d;
    end
  end

  assign slot           = out_q.slot;
  assign zero           = out_q.zero;
  assign m1_enters      = out_q.m1;
  assign m2_enters      = out_q.m2;
  assign c1_enters      = out_q.c1;
  assign c2_enters      = out_q.c2;
  assign use_prevprev1  = out_q.prevprev1;
  assign use_prev1      = out_q.prev1;
  assign use_prev2      = out_q.prev2;
  assign use_internal_x = out_q.internal_x;
  assign use_internal_y = out_q.internal_y;
  assign fb_II          = out_q.fb;
  assign con_I          = out_q.con;
`ifdef JT51_SEQ_CARRIER_EN
  assign carrier        = out_q.carrier;
`endif

endmodule

// File: tb/tb_jt51_slot_seq.sv
// Self-checking bench for jt51_slot_seq: directed scenarios plus random traffic
// compared every cycle against a slot-level behavioural model.
module tb_jt51_slot_seq;

  logic       clk = 1'b0;
  logic       rst, cen, wr;
  logic [2:0] wr_ch, wr_con, wr_fb;
  logic [4:0] slot;
  logic       zero, m1_enters, m2_enters, c1_enters, c2_enters;
  logic       use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y;
  logic [2:0] fb_II, con_I;
  logic       carrier_o;

  jt51_slot_seq dut (
    .clk(clk), .rst(rst), .cen(cen), .wr(wr),
    .wr_ch(wr_ch), .wr_con(wr_con), .wr_fb(wr_fb),
    .slot(slot), .zero(zero),
    .m1_enters(m1_enters), .m2_enters(m2_enters),
    .c1_enters(c1_enters), .c2_enters(c2_enters),
    .use_prevprev1(use_prevprev1), .use_prev1(use_prev1), .use_prev2(use_prev2),
    .use_internal_x(use_internal_x), .use_internal_y(use_internal_y),
    .fb_II(fb_II), .con_I(con_I)
`ifdef JT51_SEQ_CARRIER_EN
    , .carrier(carrier_o)
`endif
  );

`ifndef JT51_SEQ_CARRIER_EN
  assign carrier_o = 1'b0;
`endif

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot index, operator kind and routing tables per connection.
  int         cnt_m;
  logic [2:0] con_m [8];
  logic [2:0] fb_m  [8];
  logic [4:0] e_slot;
  logic       e_zero, e_car;
  logic [3:0] e_ops;   // {m1,m2,c1,c2}
  logic [4:0] e_sel;   // {prevprev1,prev1,prev2,internal_x,internal_y}
  logic [2:0] e_fb, e_con;
  int         n_m, op_m, c_m;

  always @(posedge clk) begin
    if (rst) begin
      cnt_m = 31;
      e_slot = 0; e_zero = 0; e_ops = 0; e_sel = 0; e_fb = 0; e_con = 0; e_car = 0;
      for (int i = 0; i < 8; i++) begin con_m[i] = 0; fb_m[i] = 0; end
    end else begin
      if (cen) begin
        n_m  = (cnt_m + 1) % 32;
        op_m = n_m / 8;
        c_m  = con_m[n_m % 8];
        e_fb = (cnt_m < 8) ? fb_m[cnt_m % 8] : 3'd0;
        e_slot = n_m[4:0];
        e_zero = (n_m == 0);
        e_ops  = 4'b1000 >> op_m;
        e_con  = c_m[2:0];
        e_sel[4] = (op_m == 0) || (op_m == 1 && c_m == 5);
        e_sel[3] = (op_m == 0) || (op_m == 1 && c_m == 1) ||
                   (op_m == 2 && (c_m == 0 || c_m == 3 || c_m == 5 || c_m == 6)) ||
                   (op_m == 3 && (c_m == 2 || c_m == 5));
        e_sel[2] = (op_m == 1 && c_m <= 2) || (op_m == 3 && c_m == 3);
        e_sel[1] = (op_m == 3 && c_m == 2);
        e_sel[0] = (op_m == 3 && (c_m == 0 || c_m == 1 || c_m == 3 || c_m == 4));
        e_car    = (op_m == 3) || (op_m == 1 && c_m >= 4) ||
                   (op_m == 2 && c_m >= 5) || (op_m == 0 && c_m == 7);
        cnt_m = n_m;
      end
      if (wr) begin
        con_m[wr_ch] = wr_con;
        fb_m[wr_ch]  = wr_fb;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("outputs",
            {11'd0, slot, zero, m1_enters, m2_enters, c1_enters, c2_enters,
             use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y, fb_II, con_I},
            {11'd0, e_slot, e_zero, e_ops, e_sel, e_fb, e_con});
`ifdef JT51_SEQ_CARRIER_EN
      check("carrier", {31'd0, carrier_o}, {31'd0, e_car});
`endif
    end
  end

  // Tasks start and end on a negative clock edge.
  task automatic cen_step();
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
    @(negedge clk);
  endtask

  task automatic write(input logic [2:0] ch, input logic [2:0] c, input logic [2:0] f);
    wr = 1'b1; wr_ch = ch; wr_con = c; wr_fb = f;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic advance_to(input int target);
    for (int i = 0; i < 40 && int'(e_slot) != target; i++) cen_step();
    check("reach_slot", {27'd0, slot}, target);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; wr = 1'b0; wr_ch = 0; wr_con = 0; wr_fb = 0;
    @(negedge clk);
    cen = 1'b1; wr = 1'b1; wr_ch = 3'd4; wr_con = 3'd6;
    @(negedge clk);
    cen = 1'b0; wr = 1'b0;
    checking = 1;
    check("rst_slot", {27'd0, slot}, 0);
    check("rst_flags", {m1_enters, m2_enters, c1_enters, c2_enters, zero,
                        use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y}, 0);
    check("rst_fb_con", {fb_II, con_I}, 0);
    rst = 1'b0;
    @(negedge clk);

    // One full sweep plus the wrap.
    for (int k = 0; k < 33; k++) begin
      cen_step();
      check("sweep_slot", {27'd0, slot}, k % 32);
      check("sweep_zero", {31'd0, zero}, ((k % 32) == 0) ? 1 : 0);
      check("sweep_ops", {m1_enters, m2_enters, c1_enters, c2_enters}, 4'b1000 >> ((k % 32) / 8));
    end
    @(negedge clk);
    check("hold_slot", {27'd0, slot}, 0);

    // ch3: con 0, fb 5.
    write(3'd3, 3'd0, 3'd5);
    advance_to(3);
    check("s3_m1", {m1_enters, use_prevprev1, use_prev1}, 3'b111);
    check("s3_con", {29'd0, con_I}, 0);
    cen_step();
    check("s4_fb", {29'd0, fb_II}, 5);
    advance_to(11);
    check("s11_prev2", {31'd0, use_prev2}, 1);
    advance_to(19);
    check("s19_prev1", {31'd0, use_prev1}, 1);
    advance_to(27);
    check("s27_int_y", {31'd0, use_internal_y}, 1);

    // ch5: con 2.
    write(3'd5, 3'd2, 3'd0);
    advance_to(29);
    check("s29_sel", {use_internal_x, use_prev1, use_internal_y}, 3'b110);
    advance_to(13);
    check("s13_prev2", {31'd0, use_prev2}, 1);

    // ch1: con 7 written on the very step that decodes slot 1.
    advance_to(0);
    cen = 1'b1; wr = 1'b1; wr_ch = 3'd1; wr_con = 3'd7; wr_fb = 3'd0;
    @(negedge clk);
    cen = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("s1_old_con", {27'd0, slot, con_I}, {27'd0, 5'd1, 3'd0});
    advance_to(9);
    check("s9_sel", {use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y}, 0);
    advance_to(17);
    check("s17_sel", {use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y}, 0);
    advance_to(25);
    check("s25_sel", {use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y}, 0);
    advance_to(1);
    check("s1_new_con", {29'd0, con_I}, 7);

    // Reset mid-cycle with a competing write.
    advance_to(20);
    rst = 1'b1; wr = 1'b1; wr_ch = 3'd3; wr_con = 3'd6; cen = 1'b1;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; cen = 1'b0;
    check("mid_rst_out", {slot, zero, m1_enters, m2_enters, c1_enters, c2_enters,
                          use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y,
                          fb_II, con_I}, 0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      cen_step();
      check("post_rst_slot", {27'd0, slot}, k);
      check("post_rst_con", {29'd0, con_I}, 0);
    end

`ifdef JT51_SEQ_CARRIER_EN
    write(3'd2, 3'd4, 3'd0);
    advance_to(2);
    check("car_s2", {31'd0, carrier_o}, 0);
    advance_to(10);
    check("car_s10", {31'd0, carrier_o}, 1);
    advance_to(18);
    check("car_s18", {31'd0, carrier_o}, 0);
    advance_to(26);
    check("car_s26", {31'd0, carrier_o}, 1);
`endif

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      cen    = 1'($urandom_range(0, 1));
      wr     = ($urandom_range(0, 3) == 0);
      wr_ch  = 3'($urandom);
      wr_con = 3'($urandom);
      wr_fb  = 3'($urandom);
      rst    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    cen = 1'b0; wr = 1'b0; rst = 1'b0;
    @(negedge clk);
    checking = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
